// File: rtl/fb_port_arbiter_if.sv
// Bundle of the VGA fetch, processor and frame-buffer RAM signals around the port arbiter.
// The arbiter takes the slave view; whatever drives requests and models the RAM takes the master view.
interface fb_port_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8,
  parameter int UCNT_W = 16
);
  logic              vga_active;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_rvalid;
  logic              vga_underrun;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [UCNT_W-1:0] underrun_cnt;
  logic              underrun_clr;

  modport slave (
    input  vga_active, vga_req, vga_addr,
    output vga_rdata, vga_rvalid, vga_underrun,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output underrun_cnt,
    input  underrun_clr
  );

  modport master (
    output vga_active, vga_req, vga_addr,
    input  vga_rdata, vga_rvalid, vga_underrun,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  underrun_cnt,
    output underrun_clr
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Shares the single-port frame-buffer RAM between VGA pixel fetch and the processor, with a
// starvation guard that steals an occasional active-video slot and accounts for it as an underrun.
//
// owner    | meaning
// OWN_NONE | RAM idle this slot, address held, no write
// OWN_VGA  | pixel fetch at vga_addr
// OWN_CPU  | processor read or write at cpu_addr
module fb_port_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 15,
  parameter int UCNT_W     = 16
) (
  input logic             vgaclk,
  input logic             reset,
  fb_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_CPU} owner_t;

  owner_t     owner;
  logic       forced;
  logic [7:0] starve;

  owner_t s1_owner, s2_owner;
  logic   s1_rd, s2_rd;
  logic   s1_under, s2_under;

  always_comb begin
    owner  = OWN_NONE;
    forced = 1'b0;
    if (!reset) begin
      if (bus.vga_active && bus.vga_req) begin
        if (starve < 8'(STARVE_MAX)) begin
          owner = OWN_VGA;
        end else if (bus.cpu_req) begin
          owner  = OWN_CPU;
          forced = 1'b1;
        end else begin
          owner = OWN_VGA;
        end
      end else if (bus.cpu_req) begin
        owner = OWN_CPU;
      end
    end
  end

  // Grant is seen by the processor in the same cycle its request is sampled.
  assign bus.cpu_gnt = (owner == OWN_CPU);

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      starve <= '0;
    end else if (owner == OWN_CPU || !bus.cpu_req) begin
      starve <= '0;
    end else if (starve != 8'hFF) begin
      starve <= starve + 8'd1;
    end
  end

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
    end else begin
      unique case (owner)
        OWN_VGA: begin
          bus.mem_addr <= ADDR_W'(bus.vga_addr);
          bus.mem_we   <= 1'b0;
        end
        OWN_CPU: begin
          bus.mem_addr  <= ADDR_W'(bus.cpu_addr);
          bus.mem_we    <= bus.cpu_we;
          bus.mem_wdata <= DATA_W'(bus.cpu_wdata);
        end
        default: bus.mem_we <= 1'b0;
      endcase
    end
  end

  // Tags follow each slot through the address register and the RAM's read register.
  always_ff @(posedge vgaclk) begin
    if (reset) begin
      s1_owner <= OWN_NONE;
      s1_rd    <= 1'b0;
      s1_under <= 1'b0;
      s2_owner <= OWN_NONE;
      s2_rd    <= 1'b0;
      s2_under <= 1'b0;
    end else begin
      s1_owner <= owner;
      s1_rd    <= (owner == OWN_VGA) || (owner == OWN_CPU && !bus.cpu_we);
      s1_under <= forced;
      s2_owner <= s1_owner;
      s2_rd    <= s1_rd;
      s2_under <= s1_under;
    end
  end

  // A stolen slot still emits a VGA pixel (the previous one) so the raster stays aligned.
  always_ff @(posedge vgaclk) begin
    if (reset) begin
      bus.vga_rdata  <= '0;
      bus.vga_rvalid <= 1'b0;
      bus.cpu_rdata  <= '0;
      bus.cpu_rvalid <= 1'b0;
    end else begin
      bus.vga_rvalid <= (s2_owner == OWN_VGA && s2_rd) || s2_under;
      if (s2_owner == OWN_VGA && s2_rd) begin
        bus.vga_rdata <= bus.mem_rdata;
      end
      bus.cpu_rvalid <= (s2_owner == OWN_CPU) && s2_rd;
      if (s2_owner == OWN_CPU && s2_rd) begin
        bus.cpu_rdata <= bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      bus.vga_underrun <= 1'b0;
      bus.underrun_cnt <= '0;
    end else begin
      bus.vga_underrun <= forced;
      if (bus.underrun_clr) begin
        bus.underrun_cnt <= '0;
      end else if (forced && bus.underrun_cnt != {UCNT_W{1'b1}}) begin
        bus.underrun_cnt <= bus.underrun_cnt + UCNT_W'(1);
      end
    end
  end

endmodule
